// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 board: move directions, FSM
// states, cell geometry and the per-cell helper functions.
package game_pkg;

  localparam int unsigned CELL_W    = 4;
  localparam int unsigned N_CELLS   = 16;
  localparam logic [3:0]  WIN_VALUE = 4'd11;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    SPAWN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Board index (row*4+col) of position pos on the given line, where pos 0 is
  // the cell on the edge the tiles slide toward.
  function automatic logic [3:0] cell_idx(input dir_e dir, input logic [1:0] line,
                                          input logic [1:0] pos);
    case (dir)
      DIR_LEFT:  return {line, pos};
      DIR_RIGHT: return {line, ~pos};
      DIR_UP:    return {pos, line};
      default:   return {~pos, line};
    endcase
  endfunction

  // Merged tile value, saturating at the largest encodable tile.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

endpackage

// File: rtl/line_merge.sv
// One-line 2048 slide: compact toward the edge, merge equal neighbours once
// each starting from the edge, compact again. Cell 0 is the edge cell.
module line_merge
  import game_pkg::*;
(
  input  logic [4*CELL_W-1:0] line_in,
  output logic [4*CELL_W-1:0] line_out,
  output logic                changed
);

  logic [4*CELL_W-1:0] cmp1;
  logic [4*CELL_W-1:0] merged;
  logic [2:0]          cnt1;
  logic [2:0]          cnt2;

  // First compaction: pack non-zero cells toward the edge.
  always_comb begin
    cmp1 = '0;
    cnt1 = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (line_in[j*CELL_W +: CELL_W] != '0) begin
        cmp1[cnt1*CELL_W +: CELL_W] = line_in[j*CELL_W +: CELL_W];
        cnt1 = cnt1 + 3'd1;
      end
    end
  end

  // Pairwise merge from the edge; the partner is zeroed so it cannot merge again.
  always_comb begin
    merged = cmp1;
    for (int unsigned j = 0; j < 3; j++) begin
      if (merged[j*CELL_W +: CELL_W] != '0 &&
          merged[j*CELL_W +: CELL_W] == merged[(j+1)*CELL_W +: CELL_W]) begin
        merged[j*CELL_W +: CELL_W]     = sat_inc(merged[j*CELL_W +: CELL_W]);
        merged[(j+1)*CELL_W +: CELL_W] = '0;
      end
    end
  end

  // Second compaction closes the gaps left by merges.
  always_comb begin
    line_out = '0;
    cnt2     = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (merged[j*CELL_W +: CELL_W] != '0) begin
        line_out[cnt2*CELL_W +: CELL_W] = merged[j*CELL_W +: CELL_W];
        cnt2 = cnt2 + 3'd1;
      end
    end
  end

  // Flag any difference between the input and the result.
  always_comb begin
    changed = (line_out != line_in);
  end

endmodule

// File: rtl/game_board.sv
// 4x4 2048 board: holds state, accepts debug cell writes, executes moves one
// line per cycle and (when GAME_BOARD_SPAWN_EN is defined) spawns new tiles
// at an LFSR-chosen empty cell.
module game_board
  import game_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                move_in,
  input  logic                      new_game,
  input  logic                      wr_valid,
  input  logic [3:0]                wr_addr,
  input  logic [3:0]                wr_data,
  output logic [N_CELLS*CELL_W-1:0] grid,
  output logic                      busy,
  output logic                      move_done,
  output logic                      changed,
  output logic                      win
);

  state_e                    state_q, state_d;
  dir_e                      dir_q, dir_d;
  logic [1:0]                line_q, line_d;
  logic [N_CELLS*CELL_W-1:0] grid_q, grid_d;
  logic                      changed_q, changed_d;
  logic                      move_done_q, move_done_d;
  logic                      is_move_q, is_move_d;

`ifdef GAME_BOARD_SPAWN_EN
  logic [1:0]                spawn_cnt_q, spawn_cnt_d;
  logic [3:0]                scan_start_q, scan_start_d;
  logic [3:0]                scan_k_q, scan_k_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [3:0]                spawn_idx;
`endif

  logic [4*CELL_W-1:0]       line_in;
  logic [4*CELL_W-1:0]       line_out;
  logic                      line_changed;
  dir_e                      move_dir;
  logic                      move_ok;

  line_merge u_line_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .changed  (line_changed)
  );

  // Decode the move request; anything other than exactly one bit is ignored.
  always_comb begin
    move_ok  = 1'b1;
    move_dir = DIR_UP;
    case (move_in)
      4'b0001: move_dir = DIR_UP;
      4'b0010: move_dir = DIR_DOWN;
      4'b0100: move_dir = DIR_LEFT;
      4'b1000: move_dir = DIR_RIGHT;
      default: move_ok  = 1'b0;
    endcase
  end

  // Gather the current line edge-first for the merge unit.
  always_comb begin
    line_in = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      line_in[j*CELL_W +: CELL_W] = grid_q[{cell_idx(dir_q, line_q, 2'(j)), 2'b00} +: CELL_W];
    end
  end

`ifdef GAME_BOARD_SPAWN_EN
  // Free-running Fibonacci LFSR (taps 16,14,13,11) and the cell under scan.
  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    spawn_idx = scan_start_q + scan_k_q;
  end
`endif

  // FSM next state, board updates and registered outputs.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    line_d      = line_q;
    grid_d      = grid_q;
    changed_d   = changed_q;
    move_done_d = 1'b0;
    is_move_d   = is_move_q;
`ifdef GAME_BOARD_SPAWN_EN
    spawn_cnt_d  = spawn_cnt_q;
    scan_start_d = scan_start_q;
    scan_k_d     = scan_k_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          grid_d[{wr_addr, 2'b00} +: CELL_W] = wr_data;
        end else if (new_game) begin
          grid_d    = '0;
          is_move_d = 1'b0;
          changed_d = 1'b0;
`ifdef GAME_BOARD_SPAWN_EN
          spawn_cnt_d  = 2'd2;
          scan_start_d = lfsr_q[3:0];
          scan_k_d     = '0;
          state_d      = SPAWN;
`else
          state_d      = DONE;
`endif
        end else if (move_ok) begin
          dir_d     = move_dir;
          line_d    = '0;
          changed_d = 1'b0;
          is_move_d = 1'b1;
          state_d   = SLIDE;
        end
      end
      SLIDE: begin
        for (int unsigned j = 0; j < 4; j++) begin
          grid_d[{cell_idx(dir_q, line_q, 2'(j)), 2'b00} +: CELL_W] = line_out[j*CELL_W +: CELL_W];
        end
        changed_d = changed_q | line_changed;
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) begin
`ifdef GAME_BOARD_SPAWN_EN
          if (changed_q | line_changed) begin
            spawn_cnt_d  = 2'd1;
            scan_start_d = lfsr_q[3:0];
            scan_k_d     = '0;
            state_d      = SPAWN;
          end else begin
            state_d     = DONE;
            move_done_d = is_move_q;
          end
`else
          state_d     = DONE;
          move_done_d = is_move_q;
`endif
        end
      end
`ifdef GAME_BOARD_SPAWN_EN
      SPAWN: begin
        if (grid_q[{spawn_idx, 2'b00} +: CELL_W] == '0) begin
          grid_d[{spawn_idx, 2'b00} +: CELL_W] = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
          spawn_cnt_d = spawn_cnt_q - 2'd1;
          if (spawn_cnt_q == 2'd1) begin
            state_d     = DONE;
            move_done_d = is_move_q;
          end else begin
            scan_start_d = lfsr_q[3:0];
            scan_k_d     = '0;
          end
        end else if (scan_k_q == 4'd15) begin
          // Board full: abandon the remaining spawns.
          state_d     = DONE;
          move_done_d = is_move_q;
        end else begin
          scan_k_d = scan_k_q + 4'd1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= DIR_UP;
      line_q      <= '0;
      grid_q      <= '0;
      changed_q   <= 1'b0;
      move_done_q <= 1'b0;
      is_move_q   <= 1'b0;
`ifdef GAME_BOARD_SPAWN_EN
      spawn_cnt_q  <= '0;
      scan_start_q <= '0;
      scan_k_q     <= '0;
      lfsr_q       <= LFSR_SEED;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      line_q      <= line_d;
      grid_q      <= grid_d;
      changed_q   <= changed_d;
      move_done_q <= move_done_d;
      is_move_q   <= is_move_d;
`ifdef GAME_BOARD_SPAWN_EN
      spawn_cnt_q  <= spawn_cnt_d;
      scan_start_q <= scan_start_d;
      scan_k_q     <= scan_k_d;
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  // Win flag: any tile at 2048 or above.
  always_comb begin
    win = 1'b0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (grid_q[i*CELL_W +: CELL_W] >= WIN_VALUE) win = 1'b1;
    end
  end

  assign grid      = grid_q;
  assign busy      = (state_q != IDLE);
  assign move_done = move_done_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_game_board.sv
// Bench for game_board in its deterministic build (no spawning).
module tb_game_board;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  move_in = '0;
  logic        new_game = 1'b0;
  logic        wr_valid = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic [63:0] grid;
  logic        busy, move_done, changed, win;

  always #5 clk = ~clk;

  game_board dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .move_in   (move_in),
    .new_game  (new_game),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grid      (grid),
    .busy      (busy),
    .move_done (move_done),
    .changed   (changed),
    .win       (win)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] m_board [16];
  int         phase = 0;
  bit         m_is_move = 0;
  bit         m_chg = 0;

  logic [3:0] pat [16] = '{4'd2, 4'd2, 4'd2, 4'd0,
                           4'd0, 4'd3, 4'd3, 4'd3,
                           4'd1, 4'd0, 4'd1, 4'd0,
                           4'd4, 4'd4, 4'd4, 4'd4};
  logic [3:0] pat_moves [5] = '{4'b0010, 4'b1000, 4'b0001, 4'b0100, 4'b0100};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_board();
    logic [63:0] g = '0;
    for (int i = 0; i < 16; i++) g[i*4 +: 4] = m_board[i];
    return g;
  endfunction

  function automatic logic model_win();
    logic w = 1'b0;
    for (int i = 0; i < 16; i++) if (m_board[i] >= 4'd11) w = 1'b1;
    return w;
  endfunction

  // Whole-board 2048 move on the model: dir 0 up, 1 down, 2 left, 3 right.
  function automatic void apply_move(input int dir);
    logic [3:0] nb [16];
    for (int i = 0; i < 16; i++) nb[i] = m_board[i];
    for (int k = 0; k < 4; k++) begin
      int idx [4];
      int vals [$];
      int outv [4];
      int n;
      int i;
      for (int j = 0; j < 4; j++) begin
        case (dir)
          0:       idx[j] = j*4 + k;
          1:       idx[j] = (3-j)*4 + k;
          2:       idx[j] = k*4 + j;
          default: idx[j] = k*4 + (3-j);
        endcase
        outv[j] = 0;
      end
      vals.delete();
      for (int j = 0; j < 4; j++)
        if (m_board[idx[j]] != 0) vals.push_back(int'(m_board[idx[j]]));
      n = 0;
      i = 0;
      while (i < vals.size()) begin
        if (i + 1 < vals.size() && vals[i] == vals[i+1]) begin
          outv[n] = (vals[i] + 1 > 15) ? 15 : vals[i] + 1;
          i += 2;
        end else begin
          outv[n] = vals[i];
          i += 1;
        end
        n++;
      end
      for (int j = 0; j < 4; j++) nb[idx[j]] = 4'(outv[j]);
    end
    m_chg = 0;
    for (int i = 0; i < 16; i++) begin
      if (nb[i] != m_board[i]) m_chg = 1;
      m_board[i] = nb[i];
    end
  endfunction

  // Transaction-level model plus per-cycle comparison of the DUT outputs.
  initial begin
    for (int i = 0; i < 16; i++) m_board[i] = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) m_board[i] = '0;
        phase = 0;
        m_is_move = 0;
      end else if (phase == 0) begin
        if (wr_valid) begin
          m_board[wr_addr] = wr_data;
        end else if (new_game) begin
          for (int i = 0; i < 16; i++) m_board[i] = '0;
          phase = 1;
          m_is_move = 0;
        end else if ($onehot(move_in)) begin
          int d = 0;
          for (int b = 0; b < 4; b++) if (move_in[b]) d = b;
          apply_move(d);
          phase = 5;
          m_is_move = 1;
        end
      end else begin
        phase--;
      end
      #1;
      check("busy", busy, phase != 0);
      check("move_done", move_done, (phase == 1) && m_is_move);
      if (phase <= 1) begin
        check("grid", grid, pack_board());
        check("win", win, model_win());
      end
      if (phase == 1 && m_is_move) check("changed", changed, m_chg);
    end
  end

  task automatic write_cell(input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
  endtask

  // Issue a move and wait (bounded) for move_done; lat is -1 on timeout.
  task automatic do_move(input logic [3:0] m, output int lat, output logic chg);
    lat = -1;
    chg = 1'b0;
    @(negedge clk);
    move_in = m;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) move_in = '0;
      if (move_done === 1'b1 && lat < 0) begin
        lat = c;
        chg = changed;
      end
      if (lat >= 0 && busy === 1'b0) break;
    end
  endtask

  int   lat;
  logic chg;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_grid", grid, 64'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_move_done", move_done, 1'b0);
    check("reset_changed", changed, 1'b0);
    check("reset_win", win, 1'b0);
    rst_n = 1'b1;

    // Row 0 = [1,1,2,2], move left -> [2,3,0,0]
    write_cell(4'd0, 4'd1);
    write_cell(4'd1, 4'd1);
    write_cell(4'd2, 4'd2);
    write_cell(4'd3, 4'd2);
    do_move(4'b0100, lat, chg);
    check("left_latency", lat, 5);
    check("left_changed", chg, 1'b1);
    check("left_grid", grid, 64'h32);

    // Row 0 = [1,1,1,1], move right -> [0,0,2,2]
    write_cell(4'd0, 4'd1);
    write_cell(4'd1, 4'd1);
    write_cell(4'd2, 4'd1);
    write_cell(4'd3, 4'd1);
    do_move(4'b1000, lat, chg);
    check("right_latency", lat, 5);
    check("right_changed", chg, 1'b1);
    check("right_grid", grid, 64'h2200);

    // new_game clears; row 1 = [0,0,0,1] moved right is unchanged
    start_new_game();
    check("new_game_grid", grid, 64'h0);
    write_cell(4'd7, 4'd1);
    do_move(4'b1000, lat, chg);
    check("nochg_latency", lat, 5);
    check("nochg_changed", chg, 1'b0);
    check("nochg_grid", grid, 64'h1000_0000);

    // Column 0 = [15,15,0,0], move up saturates at 15; win threshold
    start_new_game();
    write_cell(4'd0, 4'd10);
    @(negedge clk);
    check("win_below", win, 1'b0);
    write_cell(4'd0, 4'd15);
    write_cell(4'd4, 4'd15);
    do_move(4'b0001, lat, chg);
    check("sat_changed", chg, 1'b1);
    check("sat_grid", grid, 64'hF);
    check("sat_win", win, 1'b1);

    // Inputs while busy are dropped
    start_new_game();
    write_cell(4'd0, 4'd1);
    write_cell(4'd1, 4'd1);
    @(negedge clk);
    move_in = 4'b0100;
    @(negedge clk);
    move_in  = 4'b1000;
    wr_valid = 1'b1;
    wr_addr  = 4'd0;
    wr_data  = 4'd7;
    @(negedge clk);
    move_in  = '0;
    wr_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("drop_grid", grid, 64'h2);
    check("drop_busy", busy, 1'b0);

    // Non-one-hot request is ignored
    @(negedge clk);
    move_in = 4'b0101;
    @(negedge clk);
    move_in = '0;
    check("multi_hot_busy", busy, 1'b0);
    check("multi_hot_grid", grid, 64'h2);

    // Reset in the middle of a move
    write_cell(4'd3, 4'd1);
    @(negedge clk);
    move_in = 4'b0100;
    @(negedge clk);
    move_in = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_grid", grid, 64'h0);
    check("midreset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    write_cell(4'd15, 4'd3);
    do_move(4'b0001, lat, chg);
    check("post_reset_latency", lat, 5);
    check("post_reset_grid", grid, 64'h3000);

    // Mixed board through a sequence of moves, checked against the model
    for (int i = 0; i < 16; i++) write_cell(4'(i), pat[i]);
    for (int k = 0; k < 5; k++) begin
      do_move(pat_moves[k], lat, chg);
      check("seq_latency", lat, 5);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_board.md
# game_board

Holds the 4×4 2048 board state and executes moves on it. Sits between the input stage (buttons plus debug force-move) and the VGA renderer, and accepts single-cell writes from the debug controller. A move slides and merges the board one line per cycle, then optionally spawns a new tile at a pseudo-random empty cell. The full board is exported as a flat 64-bit vector, which feeds both the renderer and the debug controller's read path.

## Interface
- No parameters; board size is fixed at 4×4 with 4-bit cells.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- move_in  in  4  one-hot move request, single-cycle pulse: bit0 up, bit1 down, bit2 left, bit3 right
- new_game  in  1  pulse; clears the board, then spawns two tiles
- wr_valid  in  1  debug cell-write strobe
- wr_addr  in  4  cell index, row*4+col; row 0 is the top row, col 0 is the left column
- wr_data  in  4  cell value to write
- grid  out  64  board state; cell i occupies grid[i*4+:4]; 0 = empty, n = tile 2^n
- busy  out  1  high while a move or new game is executing
- move_done  out  1  one-cycle pulse when a move completes
- changed  out  1  valid with move_done: 1 if the slide/merge altered the board
- win  out  1  combinational; high when any cell is ≥11 (2048)

## Operation
- FSM states: IDLE, SLIDE, SPAWN, DONE.
- IDLE, priority order (one action per cycle):
  - wr_valid: write the cell; all other inputs are dropped that cycle.
  - new_game: clear the board, set spawn count to 2, go to SPAWN.
  - move_in exactly one-hot: latch the direction, clear line counter and changed flag, go to SLIDE.
  - move_in not one-hot (zero bits or several bits): ignored.
- In every state except IDLE, all inputs are ignored and dropped, with no queuing.
- SLIDE runs 4 cycles, handling line k on line-counter cycle k.
  - Left/right handle row k; up/down handle column k.
  - Cells are ordered starting from the destination edge.
  - Line operation:
    - Compact non-zero cells toward the edge.
    - Merge equal adjacent pairs starting from the edge, each cell merging at most once; merged value = n+1, saturating at 15.
    - Compact again.
  - Results are written back to the board the same cycle; changed ORs in any per-line difference.
  - After line 3: if changed, set spawn count to 1 and go to SPAWN; otherwise go to DONE.
- SPAWN:
  - On entry, the scan start is lfsr[3:0].
  - Each cycle, examine cell (start+k) mod 16.
  - The first empty cell receives value 2 (tile 4) if lfsr[7:4]==0, else 1 (tile 2).
  - Decrement the spawn count; if it is still non-zero, restart the scan with a fresh start index.
  - If 16 cells are scanned with no empty cell found, abandon the spawn.
  - When the spawn count reaches zero or the spawn is abandoned, go to DONE.
- DONE lasts 1 cycle. move_done pulses only if the sequence began as a move (not after new_game). Then return to IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, free-running every cycle, seed 16'hACE1.

## Timing
- Reset values:
  - grid = 0
  - busy = 0, move_done = 0, changed = 0
  - state = IDLE
  - lfsr = 16'hACE1
- Write accepted in cycle T is visible on grid at T+1.
- Move accepted at T: busy rises at T+1. Lines 0..3 are registered at the ends of cycles T+1..T+4.
  - Unchanged board: DONE at T+5; move_done and changed=0 at T+5.
  - Changed board: SPAWN takes 1–16 cycles, then DONE.
- busy is high in SLIDE, SPAWN and DONE.
- Reset mid-operation: the board clears to empty immediately. There is no partial move and no move_done pulse.

## Configuration
- GAME_BOARD_SPAWN_EN defined: SPAWN state and LFSR are present, behaving as described above.
- Not defined:
  - SPAWN and LFSR are removed.
  - After SLIDE, go straight to DONE.
  - new_game clears the board and completes in a single DONE cycle.
  - The board is fully deterministic, which is the intended setup for verification.

## Structure
- Shared package game_pkg holds:
  - direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT
  - state enum
  - CELL_W=4, N_CELLS=16, WIN_VALUE=11, LFSR_SEED
- One combinational sub-module, line_merge. It takes 4 cells (edge-first) and returns the 4 merged cells plus a changed bit. The FSM, line extraction/insertion and spawn logic live in game_board.

## Test plan
- Build without GAME_BOARD_SPAWN_EN. Write row 0 = [1,1,2,2], move left → row 0 = [2,3,0,0]; move_done=1 and changed=1 at T+5.
- Row 0 = [1,1,1,1], move right → [0,0,2,2]; a row of [0,0,0,1] moved right → unchanged, changed=0.
- Column 0 = [15,15,0,0] top-down, move up → [15,0,0,0] (saturating); win=1.
- Build with GAME_BOARD_SPAWN_EN, single tile 1 at cell 5, move left → cell 4 = 1. Exactly one new non-zero cell appears, its value is 1 or 2, and it lies in a previously empty cell. new_game → exactly 2 non-zero cells.
- Start a move, pulse wr_valid (addr 0, data 7) and a second move while busy → both dropped. The board reflects only the first move.
- Assert rst_n low at T+2 of a move → grid=0, busy=0, no move_done; a move issued after reset executes normally.
